// File: rtl/seg_scan_ctrl.sv
// Eight-digit seven-segment scan controller: holds one hex value per digit and
// steps the digit select through 0..7, holding each digit for REFRESH_DIV cycles.
module seg_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       clr,
  input  logic [7:0] digit_en,
  output logic [2:0] sel,
  output logic [3:0] num,
  output logic       blank,
  output logic       scan_tick
);

  localparam int unsigned DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic          advance;
  logic [3:0]    mem [8];

  assign advance = (div_cnt == DIV_LAST);

  // Prescaler and scan counter free-run; store writes and clr never touch them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      sel       <= '0;
      scan_tick <= 1'b0;
    end else begin
      scan_tick <= advance;
      if (advance) begin
        div_cnt <= '0;
        sel     <= sel + 3'd1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // clr takes priority over a same-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 8; i++) mem[i] <= '0;
    end else if (clr) begin
      for (int unsigned i = 0; i < 8; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign num   = mem[sel];
  assign blank = ~digit_en[sel];

endmodule
